// File: rtl/cadr_mux_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a shared 2:1 address/data mux bank
// feeding one memory port. Enforces break-before-make on the mux select.
module cadr_mux_arbiter #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned TW        = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic REQ_A,
  input  logic REQ_B,
  input  logic MEM_DONE,
  output logic ACK_A,
  output logic ACK_B,
  output logic ERR,
  output logic MUX_SEL,
  output logic MUX_ENB_N,
  output logic MEM_GO,
  output logic BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RELEASE
  } state_t;

  localparam logic [TW-1:0] SETUP_LAST   = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          last_b, last_b_nxt;
  logic          grant_b;
  logic          ack_a_nxt, ack_b_nxt, err_nxt;
  logic          sel_nxt, enb_n_nxt, go_nxt, busy_nxt;

  // On a tie B wins only when A was served last; a lone request wins outright.
  assign grant_b = REQ_B & (~REQ_A | ~last_b);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_b_nxt = last_b;
    sel_nxt    = MUX_SEL;
    enb_n_nxt  = MUX_ENB_N;
    busy_nxt   = BUSY;
    go_nxt     = 1'b0;
    ack_a_nxt  = 1'b0;
    ack_b_nxt  = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        enb_n_nxt = 1'b1;
        busy_nxt  = 1'b0;
        if (REQ_A || REQ_B) begin
          sel_nxt   = grant_b;
          enb_n_nxt = 1'b0;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          go_nxt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ACCESS;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      ACCESS: begin
        // MEM_DONE on the final timeout cycle still counts as a clean completion.
        if (MEM_DONE || (cnt == TIMEOUT_LAST)) begin
          ack_a_nxt = ~MUX_SEL;
          ack_b_nxt = MUX_SEL;
          err_nxt   = ~MEM_DONE;
          state_nxt = RELEASE;
        end else begin
          go_nxt  = 1'b1;
          cnt_nxt = cnt + TW'(1);
        end
      end
      RELEASE: begin
        enb_n_nxt  = 1'b1;
        busy_nxt   = 1'b0;
        last_b_nxt = MUX_SEL;
        state_nxt  = IDLE;
      end
      default: begin
        enb_n_nxt = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cnt       <= '0;
      last_b    <= 1'b1;
      MUX_SEL   <= 1'b0;
      MUX_ENB_N <= 1'b1;
      MEM_GO    <= 1'b0;
      ACK_A     <= 1'b0;
      ACK_B     <= 1'b0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last_b    <= last_b_nxt;
      MUX_SEL   <= sel_nxt;
      MUX_ENB_N <= enb_n_nxt;
      MEM_GO    <= go_nxt;
      ACK_A     <= ack_a_nxt;
      ACK_B     <= ack_b_nxt;
      ERR       <= err_nxt;
      BUSY      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_cadr_mux_arbiter.sv
// Bench for cadr_mux_arbiter: two instances (SETUP_CYC=1/TIMEOUT=15 and SETUP_CYC=3/TIMEOUT=4)
// compared every cycle against a timeline model indexed by cycles since the grant.
module tb_cadr_mux_arbiter;
  localparam int unsigned S0 = 1, T0 = 15, S1 = 3, T1 = 4;
  localparam logic [6:0] RST_OUT = 7'b0000100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_a, req_b, done;
  logic [1:0] ack_a, ack_b, err, sel, enb_n, go, busy;

  always #5 clk = ~clk;

  cadr_mux_arbiter #(.SETUP_CYC(S0), .TIMEOUT(T0), .TW(4)) dut0 (
    .CLK(clk), .RESET_N(rst_n), .REQ_A(req_a[0]), .REQ_B(req_b[0]), .MEM_DONE(done[0]),
    .ACK_A(ack_a[0]), .ACK_B(ack_b[0]), .ERR(err[0]), .MUX_SEL(sel[0]),
    .MUX_ENB_N(enb_n[0]), .MEM_GO(go[0]), .BUSY(busy[0]));

  cadr_mux_arbiter #(.SETUP_CYC(S1), .TIMEOUT(T1), .TW(4)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .REQ_A(req_a[1]), .REQ_B(req_b[1]), .MEM_DONE(done[1]),
    .ACK_A(ack_a[1]), .ACK_B(ack_b[1]), .ERR(err[1]), .MUX_SEL(sel[1]),
    .MUX_ENB_N(enb_n[1]), .MEM_GO(go[1]), .BUSY(busy[1]));

  int vectors = 0;
  int miscompares = 0;

  // Model: k = index of the current cycle counted from the grant edge (1 = first SETUP cycle);
  // done_at = ACCESS cycles used once the access has finished, 0 while still waiting.
  bit          m_act [2];
  bit          m_g [2];
  bit          m_last [2];
  bit          m_sel [2];
  bit          m_err [2];
  int unsigned m_k [2];
  int unsigned m_done_at [2];
  int unsigned ms [2];
  int unsigned mt [2];
  logic        prev_sel [2];
  logic        prev_enb [2];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic expired(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed wait bound expired expected completion", tag);
  endtask

  // {ack_a, ack_b, err, sel, enb_n, go, busy}
  function automatic logic [6:0] obs(input int i);
    return {ack_a[i], ack_b[i], err[i], sel[i], enb_n[i], go[i], busy[i]};
  endfunction

  function automatic logic [6:0] expect_out(input int i);
    logic [6:0] e;
    if (!m_act[i])                 e = {3'b000, m_sel[i], 1'b1, 1'b0, 1'b0};
    else if (m_k[i] <= ms[i])      e = {3'b000, m_g[i], 1'b0, 1'b0, 1'b1};
    else if (m_done_at[i] == 0)    e = {3'b000, m_g[i], 1'b0, 1'b1, 1'b1};
    else                           e = {~m_g[i], m_g[i], m_err[i], m_g[i], 1'b0, 1'b0, 1'b1};
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_last[i] = 1; m_sel[i] = 0; m_g[i] = 0; m_err[i] = 0;
      m_k[i] = 0; m_done_at[i] = 0; prev_sel[i] = 1'b0; prev_enb[i] = 1'b1;
    end
  endtask

  task automatic advance(input int i);
    int unsigned a;
    if (!m_act[i]) begin
      if (req_a[i] || req_b[i]) begin
        m_g[i] = (req_a[i] && req_b[i]) ? ~m_last[i] : req_b[i];
        m_sel[i] = m_g[i]; m_act[i] = 1; m_k[i] = 1; m_done_at[i] = 0; m_err[i] = 0;
      end
    end else if (m_k[i] <= ms[i]) begin
      m_k[i]++;
    end else if (m_done_at[i] == 0) begin
      a = m_k[i] - ms[i];
      if (done[i]) begin m_done_at[i] = a; m_err[i] = 0; end
      else if (a == mt[i]) begin m_done_at[i] = a; m_err[i] = 1; end
      m_k[i]++;
    end else begin
      m_act[i] = 0; m_last[i] = m_g[i];
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 2; i++) advance(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("outs%0d", i), 32'(obs(i)), 32'(expect_out(i)));
      if (sel[i] !== prev_sel[i]) chk($sformatf("bbm%0d", i), 32'(prev_enb[i]), 32'd1);
      prev_sel[i] = sel[i];
      prev_enb[i] = enb_n[i];
    end
  endtask

  // Registered requesters: drop REQ in the cycle after their ACK.
  task automatic auto_drop();
    logic [6:0] e;
    for (int i = 0; i < 2; i++) begin
      e = expect_out(i);
      if (e[6]) req_a[i] = 1'b0;
      if (e[5]) req_b[i] = 1'b0;
    end
  endtask

  task automatic serve(input int bound);
    for (int n = 0; n < bound; n++) begin
      auto_drop();
      if (!m_act[0] && !m_act[1] && req_a == 2'b00 && req_b == 2'b00) return;
      tick();
    end
    expired("serve");
  endtask

  task automatic wait_ack(input int i, input int bound, output int go_cnt);
    logic [6:0] e;
    go_cnt = 0;
    for (int n = 0; n < bound; n++) begin
      e = expect_out(i);
      if (e[6] || e[5]) return;
      if (i == 0) done[0] = (done[0] === 1'b1 && m_done_at[0] == 0) ? done[0] : done[0];
      tick();
      if (go[i] === 1'b1) go_cnt++;
    end
    expired("wait_ack");
  endtask

  initial begin
    int          c, gcnt, first_go;
    logic [6:0]  e;
    ms[0] = S0; mt[0] = T0; ms[1] = S1; mt[1] = T1;
    rst_n = 1'b0; req_a = '0; req_b = '0; done = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset0", 32'(obs(0)), 32'(RST_OUT));
    chk("reset1", 32'(obs(1)), 32'(RST_OUT));
    rst_n = 1'b1;

    // Single A request with MEM_DONE tied high.
    req_a[0] = 1'b1; done[0] = 1'b1;
    tick(); chk("t1_c1_sel_enb_go", 32'({sel[0], enb_n[0], go[0]}), 32'b000);
    tick(); chk("t1_c2_go", 32'(go[0]), 32'd1);
    tick(); chk("t1_c3_ack_err_go", 32'({ack_a[0], err[0], go[0]}), 32'b100);
    req_a[0] = 1'b0;
    tick(); chk("t1_c4_enb_busy", 32'({enb_n[0], busy[0]}), 32'b10);
    serve(10);

    // Both held continuously: grants alternate, starting with B since A was served last.
    req_a[0] = 1'b1; req_b[0] = 1'b1; done[0] = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_ack(0, 12, gcnt);
      chk("t2_grant_order", 32'({ack_a[0], ack_b[0]}), (g % 2 == 0) ? 32'b01 : 32'b10);
      if (g < 3) tick();
    end
    req_a[0] = 1'b0; req_b[0] = 1'b0;
    serve(10);

    // B alone with MEM_DONE held low: timeout after T0 ACCESS cycles.
    req_b[0] = 1'b1; done[0] = 1'b0;
    wait_ack(0, 40, gcnt);
    chk("t3_go_len", 32'(gcnt), 32'(T0));
    chk("t3_ack_err", 32'({ack_b[0], err[0]}), 32'b11);
    serve(10);

    // MEM_DONE only on the last permitted ACCESS cycle.
    req_a[0] = 1'b1; done[0] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      e = expect_out(0);
      if (e[6] || e[5]) break;
      done[0] = (m_act[0] && m_k[0] > S0 && m_done_at[0] == 0 && (m_k[0] - S0) == T0);
      tick();
    end
    chk("t4_ack_err", 32'({ack_a[0], err[0]}), 32'b10);
    done[0] = 1'b0;
    serve(10);

    // Async reset in the middle of a B access, with A also pending.
    req_b[0] = 1'b1; done[0] = 1'b0;
    for (int n = 0; n < S0 + 3; n++) tick();
    chk("t5_pre_go_sel", 32'({go[0], sel[0]}), 32'b11);
    req_a[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("t5_async_reset", 32'(obs(0)), 32'(RST_OUT));
    model_reset();
    @(negedge clk);
    chk("t5_held_reset", 32'(obs(0)), 32'(RST_OUT));
    rst_n = 1'b1; done[0] = 1'b1;
    tick(); chk("t5_first_grant", 32'({sel[0], enb_n[0]}), 32'b00);
    serve(20);

    // SETUP_CYC=3 instance: REQ_A dropped in SETUP, MEM_DONE on the 2nd ACCESS cycle.
    req_a[1] = 1'b1; done[1] = 1'b0;
    tick(); c = 1; gcnt = 0; first_go = 0;
    req_a[1] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      e = expect_out(1);
      if (e[6] || e[5]) break;
      done[1] = (m_act[1] && m_k[1] > S1 && m_done_at[1] == 0 && (m_k[1] - S1) == 2);
      tick(); c++;
      if (go[1] === 1'b1) begin gcnt++; if (first_go == 0) first_go = c; end
    end
    chk("t6_first_go", 32'(first_go), 32'(1 + S1));
    chk("t6_go_len", 32'(gcnt), 32'd2);
    chk("t6_ack_cycle", 32'(c), 32'(1 + S1 + 2));
    chk("t6_ack_err", 32'({ack_a[1], err[1]}), 32'b10);
    done[1] = 1'b0;
    serve(10);

    // Randomised traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      auto_drop();
      for (int i = 0; i < 2; i++) begin
        e = expect_out(i);
        if (!req_a[i] && !e[6] && !(m_act[i] && m_g[i] == 1'b0)) req_a[i] = ($urandom_range(0, 2) == 0);
        if (!req_b[i] && !e[5] && !(m_act[i] && m_g[i] == 1'b1)) req_b[i] = ($urandom_range(0, 2) == 0);
        done[i] = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    serve(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
